// File: rtl/traffic_light_ctrl_pkg.sv
// Shared traffic-light definitions: state width and state encodings.
// Imported by the controller and by any status/display block that decodes
// the exported state bus.
package traffic_light_ctrl_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      RED     = 3'd0,
      YELLOW1 = 3'd1,
      GREEN   = 3'd2,
      YELLOW2 = 3'd3,
      BLINK   = 3'd4
   } tl_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Board button conditioner: 2-FF synchronizer followed by a stability
// down-counter. The output follows the synchronized input only after it has
// differed from the output for DEB_CYC consecutive samples.
module btn_debounce #(
   parameter int DEB_CYC = 16
) (
   input  logic clk,
   input  logic btn_res,
   input  logic in,
   output logic out
);

   localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] stab_cnt;

   // two-stage synchronizer for the asynchronous raw input
   always_ff @(posedge clk or negedge btn_res) begin
      if (!btn_res) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= in;
         sync2 <= sync1;
      end
   end

   // stability counter; any sample equal to the output restarts the count
   always_ff @(posedge clk or negedge btn_res) begin
      if (!btn_res) begin
         stab_cnt <= CNT_LOAD;
         out      <= 1'b0;
      end else if (sync2 == out) begin
         stab_cnt <= CNT_LOAD;
      end else if (stab_cnt == '0) begin
         stab_cnt <= CNT_LOAD;
         out      <= sync2;
      end else begin
         stab_cnt <= stab_cnt - 1'b1;
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Traffic-light controller with programmable phase lengths, a debounced
// pedestrian request that can cut green short, and a blinking-yellow night
// mode. All phase timing advances on a shared prescaler tick.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RED     | red lamp, timer runs T_RED ticks
//   YELLOW1 | yellow after red, T_YEL ticks
//   GREEN   | green, T_GRN ticks or cut early by a pending request
//   YELLOW2 | yellow after green, T_YEL ticks, then RED
//   BLINK   | night mode, yellow toggles every tick until night drops
//   5..7    | illegal, recover to RED on the next clock
module traffic_light_ctrl
   import traffic_light_ctrl_pkg::*;
#(
   parameter int DIV       = 50000000,
   parameter int CNT_W     = 8,
   parameter int T_RED     = 5,
   parameter int T_YEL     = 2,
   parameter int T_GRN     = 5,
   parameter int T_GRN_MIN = 2,
   parameter int DEB_CYC   = 16
) (
   input  logic            clk,
   input  logic            btn_res,
   input  logic            btn,
   input  logic            night,
   output logic            led0,
   output logic            led1,
   output logic            led2,
   output logic [ST_W-1:0] state,
   output logic            req_pend
);

   localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST  = PW'(DIV - 1);
   localparam logic [CNT_W-1:0] T_RED_C   = CNT_W'(T_RED);
   localparam logic [CNT_W-1:0] T_YEL_C   = CNT_W'(T_YEL);
   localparam logic [CNT_W-1:0] T_GRN_C   = CNT_W'(T_GRN);
   localparam logic [CNT_W:0]   T_MIN_W   = (CNT_W+1)'(T_GRN_MIN);
   localparam logic [CNT_W:0]   ONE_W     = (CNT_W+1)'(1);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   logic [PW-1:0]    pre_cnt;
   logic             tick;
   logic             night_s1;
   logic             night_s;
   logic             deb_out;
   logic             deb_d;
   logic             req_evt;
   logic             in_road;
   tl_state_e        st;
   logic [CNT_W-1:0] timer;
   logic             blink;
   logic [CNT_W:0]   grn_elapsed;

   // free-running prescaler, one tick per DIV clocks
   always_ff @(posedge clk or negedge btn_res) begin
      if (!btn_res) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   // night switch synchronizer; a level, so no debounce needed
   always_ff @(posedge clk or negedge btn_res) begin
      if (!btn_res) begin
         night_s1 <= 1'b0;
         night_s  <= 1'b0;
      end else begin
         night_s1 <= night;
         night_s  <= night_s1;
      end
   end

   btn_debounce #(
      .DEB_CYC (DEB_CYC)
   ) u_btn_deb (
      .clk     (clk),
      .btn_res (btn_res),
      .in      (btn),
      .out     (deb_out)
   );

   // delayed debounced level for rising-edge detection
   always_ff @(posedge clk or negedge btn_res) begin
      if (!btn_res) begin
         deb_d <= 1'b0;
      end else begin
         deb_d <= deb_out;
      end
   end

   assign req_evt     = deb_out & ~deb_d;
   assign in_road     = (st == YELLOW1) | (st == GREEN) | (st == YELLOW2);
   assign grn_elapsed = {1'b0, T_GRN_C} - {1'b0, timer} + ONE_W;

   // phase FSM with timer, request latch and blink phase
   always_ff @(posedge clk or negedge btn_res) begin
      if (!btn_res) begin
         st       <= RED;
         timer    <= T_RED_C;
         req_pend <= 1'b0;
         blink    <= 1'b0;
      end else begin
         // set first so any clear below in the same cycle overrides it
         if (req_evt && in_road) begin
            req_pend <= 1'b1;
         end
         case (st)
            RED, YELLOW1, GREEN, YELLOW2, BLINK: begin
               if (tick) begin
                  if (night_s && (st != BLINK)) begin
                     // blink is 0 outside BLINK, so the entry tick toggles it to 1
                     st       <= BLINK;
                     blink    <= 1'b1;
                     req_pend <= 1'b0;
                  end else if (st == BLINK) begin
                     if (!night_s) begin
                        st       <= RED;
                        timer    <= T_RED_C;
                        blink    <= 1'b0;
                        req_pend <= 1'b0;
                     end else begin
                        blink <= ~blink;
                     end
                  end else if ((st == GREEN) && req_pend && (grn_elapsed >= T_MIN_W)) begin
                     st    <= YELLOW2;
                     timer <= T_YEL_C;
                  end else if (timer > ONE_C) begin
                     timer <= timer - ONE_C;
                  end else begin
                     case (st)
                        RED: begin
                           st    <= YELLOW1;
                           timer <= T_YEL_C;
                        end
                        YELLOW1: begin
                           st    <= GREEN;
                           timer <= T_GRN_C;
                        end
                        GREEN: begin
                           st    <= YELLOW2;
                           timer <= T_YEL_C;
                        end
                        default: begin
                           st       <= RED;
                           timer    <= T_RED_C;
                           req_pend <= 1'b0;
                        end
                     endcase
                  end
               end
            end
            default: begin
               st       <= RED;
               timer    <= T_RED_C;
               req_pend <= 1'b0;
               blink    <= 1'b0;
            end
         endcase
      end
   end

   assign led0  = (st == RED);
   assign led1  = (st == YELLOW1) | (st == YELLOW2) | ((st == BLINK) & blink);
   assign led2  = (st == GREEN);
   assign state = st;

endmodule
